// File: rtl/cv32e40x_div_iter.sv
// rtl/cv32e40x_div_iter.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module cv32e40x_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        div_clz_en_o,
  output logic [31:0] div_clz_data_o,
  input  logic [5:0]  div_clz_result_i,
  output logic        div_shift_en_o,
  output logic [5:0]  div_shift_amt_o,
  output logic [31:0] div_alu_op_a_o,
  input  logic [31:0] div_op_a_shifted_i
);

  typedef enum logic [2:0] {IDLE, CLZ, SHIFT, ITER, DONE} state_t;

  state_t      state, next_state;
  logic        is_rem;
  logic        sign_a, sign_b;
  logic [31:0] abs_a, abs_b;
  logic [4:0]  cnt;
  logic [31:0] d_q, r_q, q_q;
  logic [31:0] result_q;
  logic        valid_q;

  logic        in_sign_a, in_sign_b;
  logic [31:0] in_abs_a, in_abs_b;
  logic        b_zero;
  logic        ge;
  logic [31:0] r_step, q_step;
  logic [31:0] quo_res, rem_res, final_res;

  // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude
  always_comb begin
    in_sign_a = ~operator_i[0] & op_a_i[31];
    in_sign_b = ~operator_i[0] & op_b_i[31];
    in_abs_a  = in_sign_a ? (~op_a_i + 32'd1) : op_a_i;
    in_abs_b  = in_sign_b ? (~op_b_i + 32'd1) : op_b_i;
    b_zero    = (op_b_i == 32'd0);
  end

  // One restoring step plus the sign-corrected result of that step
  always_comb begin
    ge        = (r_q >= d_q);
    r_step    = ge ? (r_q - d_q) : r_q;
    q_step    = {q_q[30:0], ge};
    quo_res   = (sign_a ^ sign_b) ? (~q_step + 32'd1) : q_step;
    rem_res   = sign_a ? (~r_step + 32'd1) : r_step;
    final_res = is_rem ? rem_res : quo_res;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; kill overrides every other transition
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_i) next_state = b_zero ? DONE : CLZ;
      CLZ:     next_state = SHIFT;
      SHIFT:   next_state = ITER;
      ITER:    if (cnt == 5'd0) next_state = DONE;
      DONE:    if (ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (kill_i) next_state = IDLE;
  end

  // Datapath registers; a kill only drops valid, stale data is harmless once back in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_rem   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      abs_a    <= 32'd0;
      abs_b    <= 32'd0;
      cnt      <= 5'd0;
      d_q      <= 32'd0;
      r_q      <= 32'd0;
      q_q      <= 32'd0;
      result_q <= 32'd0;
      valid_q  <= 1'b0;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            is_rem <= operator_i[1];
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            abs_a  <= in_abs_a;
            abs_b  <= in_abs_b;
            if (b_zero) begin
              result_q <= operator_i[1] ? op_a_i : 32'hFFFF_FFFF;
              valid_q  <= 1'b1;
            end
          end
        end
        CLZ: begin
          // absB is nonzero here, so bit 5 is never set; clamp anyway
          cnt <= div_clz_result_i[5] ? 5'd31 : div_clz_result_i[4:0];
        end
        SHIFT: begin
          d_q <= div_op_a_shifted_i;
          r_q <= abs_a;
          q_q <= 32'd0;
        end
        ITER: begin
          r_q <= r_step;
          q_q <= q_step;
          d_q <= d_q >> 1;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            result_q <= final_res;
            valid_q  <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) valid_q <= 1'b0;
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  // Output drive; ALU side-band ports are held at zero outside their states
  always_comb begin
    ready_o         = (state == IDLE);
    valid_o         = valid_q;
    result_o        = result_q;
    div_clz_en_o    = (state == CLZ);
    div_clz_data_o  = (state == CLZ) ? abs_b : 32'd0;
    div_shift_en_o  = (state == SHIFT);
    div_shift_amt_o = (state == SHIFT) ? {1'b0, cnt} : 6'd0;
    div_alu_op_a_o  = (state == SHIFT) ? abs_b : 32'd0;
  end

endmodule

// File: tb/tb_cv32e40x_div_iter.sv
// tb/tb_cv32e40x_div_iter.sv - directed self-checking bench for cv32e40x_div_iter
module tb_cv32e40x_div_iter;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  operator_i = 2'b00;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic        div_clz_en_o;
  logic [31:0] div_clz_data_o;
  logic [5:0]  div_clz_result_i;
  logic        div_shift_en_o;
  logic [5:0]  div_shift_amt_o;
  logic [31:0] div_alu_op_a_o;
  logic [31:0] div_op_a_shifted_i;

  int total = 0;
  int bad = 0;
  logic seen_en = 1'b0;
  logic seen_valid = 1'b0;

  always #5 clk = ~clk;

  cv32e40x_div_iter dut (
    .clk                (clk),
    .rst                (rst),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .operator_i         (operator_i),
    .op_a_i             (op_a_i),
    .op_b_i             (op_b_i),
    .kill_i             (kill_i),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .result_o           (result_o),
    .div_clz_en_o       (div_clz_en_o),
    .div_clz_data_o     (div_clz_data_o),
    .div_clz_result_i   (div_clz_result_i),
    .div_shift_en_o     (div_shift_en_o),
    .div_shift_amt_o    (div_shift_amt_o),
    .div_alu_op_a_o     (div_alu_op_a_o),
    .div_op_a_shifted_i (div_op_a_shifted_i)
  );

  // ALU stand-in: count leading zeros and left shifter
  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        n = 6'(31 - i);
        break;
      end
    end
    return n;
  endfunction

  assign div_clz_result_i   = clz32(div_clz_data_o);
  assign div_op_a_shifted_i = div_alu_op_a_o << div_shift_amt_o;

  // Side monitors sampled away from the active edge
  always @(negedge clk) begin
    if (div_clz_en_o || div_shift_en_o) seen_en <= 1'b1;
    if (valid_o === 1'b1) seen_valid <= 1'b1;
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    seen_en    = 1'b0;
    valid_i    = 1'b1;
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result_o;
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_out: ready=%b valid=%b result=%h, want 1 0 0", ready_o, valid_o, result_o);
    end
    total++;
    if (div_clz_en_o !== 1'b0 || div_shift_en_o !== 1'b0 || div_shift_amt_o !== 6'd0) begin
      bad++;
      $display("FAIL reset_alu: clz_en=%b shift_en=%b amt=%0d, want 0 0 0",
               div_clz_en_o, div_shift_en_o, div_shift_amt_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
    total++;
    if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7: got %h want %h", r, 32'd14); end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL divu_100_7_lat: got %0d want 33", lat); end
    release_result();
    run_op(OP_REMU, 32'd100, 32'd7, r, lat);
    total++;
    if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7: got %h want %h", r, 32'd2); end
    release_result();
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, r, lat);
    total++;
    if (r !== 32'd1) begin bad++; $display("FAIL divu_max_msb: got %h want %h", r, 32'd1); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL divu_max_msb_lat: got %0d want 4", lat); end
    release_result();
  endtask

  task automatic test_signed();
    logic [31:0] r;
    int lat;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
    total++;
    if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_m7_2: got %h want %h", r, 32'hFFFF_FFFD); end
    release_result();
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat);
    total++;
    if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_m7_2: got %h want %h", r, 32'hFFFF_FFFF); end
    release_result();
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, r, lat);
    total++;
    if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_7_m2: got %h want %h", r, 32'hFFFF_FFFD); end
    release_result();
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int lat;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    total++;
    if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf: got %h want %h", r, 32'h8000_0000); end
    total++;
    if (lat !== 35) begin bad++; $display("FAIL div_ovf_lat: got %0d want 35", lat); end
    release_result();
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL rem_ovf: got %h want %h", r, 32'd0); end
    release_result();
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int lat;
    run_op(OP_DIVU, 32'd5, 32'd0, r, lat);
    total++;
    if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by0: got %h want %h", r, 32'hFFFF_FFFF); end
    total++;
    if (lat !== 1) begin bad++; $display("FAIL divu_by0_lat: got %0d want 1", lat); end
    total++;
    if (seen_en !== 1'b0) begin bad++; $display("FAIL by0_no_alu: enable pulse seen=%b want 0", seen_en); end
    release_result();
    run_op(OP_REM, 32'd5, 32'd0, r, lat);
    total++;
    if (r !== 32'd5) begin bad++; $display("FAIL rem_by0: got %h want %h", r, 32'd5); end
    release_result();
  endtask

  task automatic test_stall();
    logic [31:0] r;
    int lat;
    int errs;
    run_op(OP_DIVU, 32'd50, 32'd6, r, lat);
    total++;
    if (r !== 32'd8) begin bad++; $display("FAIL stall_res: got %h want %h", r, 32'd8); end
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b1 || result_o !== 32'd8 || ready_o !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_hold: %0d bad cycles, last valid=%b result=%h ready=%b, want 1 8 0",
               errs, valid_o, result_o, ready_o);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: ready=%b valid=%b, want 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    run_op(OP_REMU, 32'd1000, 32'd13, r, lat);
    total++;
    if (r !== 32'd12) begin bad++; $display("FAIL b2b_remu: got %h want %h", r, 32'd12); end
    release_result();
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF6, r, lat);
    total++;
    if (r !== 32'd10) begin bad++; $display("FAIL b2b_div: got %h want %h", r, 32'd10); end
    release_result();
  endtask

  task automatic test_kill();
    logic [31:0] r;
    int lat;
    @(negedge clk);
    valid_i    = 1'b1;
    operator_i = OP_DIVU;
    op_a_i     = 32'd100;
    op_b_i     = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle: ready=%b valid=%b, want 1 0", ready_o, valid_o);
    end
    seen_valid = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (seen_valid !== 1'b0) begin bad++; $display("FAIL kill_no_valid: valid seen=%b want 0", seen_valid); end
    run_op(OP_DIVU, 32'd9, 32'd3, r, lat);
    total++;
    if (r !== 32'd3) begin bad++; $display("FAIL kill_next: got %h want %h", r, 32'd3); end
    release_result();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    valid_i    = 1'b1;
    operator_i = OP_DIVU;
    op_a_i     = 32'd100;
    op_b_i     = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0 ||
        div_clz_en_o !== 1'b0 || div_shift_en_o !== 1'b0 || div_shift_amt_o !== 6'd0) begin
      bad++;
      $display("FAIL async_rst: ready=%b valid=%b result=%h clz_en=%b shift_en=%b amt=%0d, want 1 0 0 0 0 0",
               ready_o, valid_o, result_o, div_clz_en_o, div_shift_en_o, div_shift_amt_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_stall();
    test_back_to_back();
    test_kill();
    test_async_reset();
    begin
      logic [31:0] r;
      int lat;
      run_op(OP_DIVU, 32'd9, 32'd3, r, lat);
      total++;
      if (r !== 32'd3) begin bad++; $display("FAIL post_rst: got %h want %h", r, 32'd3); end
      release_result();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
